// File: rtl/counter_ring_pkg.sv
// Shared constants and bit-level helpers for the ring/Johnson counter.
// Helpers use a fixed maximum width and take the live width n, so one set serves every N.
package counter_ring_pkg;

   localparam int unsigned MAX_N = 64;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;
   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;

   typedef logic [MAX_N-1:0] vec_t;

   // Ring restarts from bit 0 set; Johnson restarts from all zeros.
   function automatic vec_t seed_f(input logic mode);
      vec_t r;
      r = '0;
      if (mode == MODE_RING) r[0] = 1'b1;
      return r;
   endfunction

   // One shift step; Johnson inverts the bit that wraps around.
   function automatic vec_t step_f(input vec_t q, input int unsigned n,
                                   input logic mode, input logic dir);
      vec_t r;
      r = '0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (i < n) begin
            if (dir == DIR_UP) begin
               if (i == 0) r[i] = (mode == MODE_JOHNSON) ? ~q[n-1] : q[n-1];
               else        r[i] = q[i-1];
            end else begin
               if (i == n - 1) r[i] = (mode == MODE_JOHNSON) ? ~q[0] : q[0];
               else            r[i] = q[i+1];
            end
         end
      end
      return r;
   endfunction

   function automatic int unsigned popcount_f(input vec_t q, input int unsigned n);
      int unsigned ones;
      ones = 0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (i < n && q[i]) ones++;
      end
      return ones;
   endfunction

   // Johnson legality: a thermometer code has at most one 0/1 boundary.
   function automatic logic legal_f(input vec_t q, input int unsigned n, input logic mode);
      int unsigned edges;
      edges = 0;
      for (int unsigned i = 1; i < MAX_N; i++) begin
         if (i < n && q[i] != q[i-1]) edges++;
      end
      if (mode == MODE_RING) return popcount_f(q, n) == 1;
      return edges <= 1;
   endfunction

   // Phase of a legal state; callers zero it for illegal states.
   function automatic int unsigned phase_f(input vec_t q, input int unsigned n, input logic mode);
      int unsigned idx;
      idx = 0;
      if (mode == MODE_RING) begin
         for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n && q[i]) idx = i;
         end
      end else if (q[n-1]) begin
         idx = 2 * n - popcount_f(q, n);
      end else begin
         idx = popcount_f(q, n);
      end
      return idx;
   endfunction

endpackage

// File: rtl/counter_ring_decode.sv
// Combinational legality check and binary phase decode of an N-bit pattern.
module counter_ring_decode
   import counter_ring_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned PW = $clog2(2 * N)
) (
   input  logic [N-1:0]  q,
   input  logic          mode,
   output logic          legal_c,
   output logic [PW-1:0] phase_c
);

   vec_t q_ext;

   always_comb begin
      q_ext   = vec_t'(q);
      legal_c = legal_f(q_ext, N, mode);
      phase_c = '0;
      if (legal_c) phase_c = PW'(phase_f(q_ext, N, mode));
   end

endmodule

// File: rtl/counter_ring_multimode.sv
// N-bit ring / Johnson shift counter with load, self-correction, wrap pulse and phase decode.
module counter_ring_multimode
   import counter_ring_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned PW = $clog2(2 * N)
) (
   input  logic          clk,
   input  logic          ori,
   input  logic          en,
   input  logic          dir,
   input  logic          mode,
   input  logic          load,
   input  logic [N-1:0]  load_val,
   output logic [N-1:0]  Q,
   output logic [PW-1:0] phase,
   output logic          wrap,
   output logic          err
);

   logic          mode_q;
   logic [N-1:0]  q_nxt;
   logic          mode_nxt;
   logic          wrap_nxt;
   logic          err_nxt;
   logic          q_legal;
   logic          ld_legal;
   logic [PW-1:0] ld_phase_unused;
   logic [N-1:0]  seed_cur;
   logic [N-1:0]  seed_new;
   logic [N-1:0]  step_val;

   counter_ring_decode #(.N(N)) u_dec_q (
      .q       (Q),
      .mode    (mode_q),
      .legal_c (q_legal),
      .phase_c (phase)
   );

   // Load patterns are judged against the mode already in effect.
   counter_ring_decode #(.N(N)) u_dec_ld (
      .q       (load_val),
      .mode    (mode_q),
      .legal_c (ld_legal),
      .phase_c (ld_phase_unused)
   );

   always_comb begin
      seed_cur = N'(seed_f(mode_q));
      seed_new = N'(seed_f(mode));
      step_val = N'(step_f(vec_t'(Q), N, mode_q, dir));
   end

   // Priority: mode change, load, correction, step, hold.
   always_comb begin
      q_nxt    = Q;
      mode_nxt = mode_q;
      wrap_nxt = 1'b0;
      err_nxt  = err;
      if (mode != mode_q) begin
         q_nxt    = seed_new;
         mode_nxt = mode;
      end else if (load) begin
         if (ld_legal) begin
            q_nxt   = load_val;
            err_nxt = 1'b0;
         end else begin
            q_nxt   = seed_cur;
            err_nxt = 1'b1;
         end
      end else if (en) begin
         if (!q_legal) begin
            q_nxt   = seed_cur;
            err_nxt = 1'b1;
         end else begin
            q_nxt    = step_val;
            wrap_nxt = (step_val == seed_cur);
         end
      end
   end

   always_ff @(posedge clk or negedge ori) begin
      if (!ori) begin
         Q      <= N'(seed_f(MODE_RING));
         mode_q <= MODE_RING;
         wrap   <= 1'b0;
         err    <= 1'b0;
      end else begin
         Q      <= q_nxt;
         mode_q <= mode_nxt;
         wrap   <= wrap_nxt;
         err    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_counter_ring_multimode.sv
// Scoreboard bench for counter_ring_multimode at N=4 using a table-driven reference model.
module tb_counter_ring_multimode;

   logic       clk;
   logic       ori;
   logic       en;
   logic       dir;
   logic       mode;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] Q;
   logic [2:0] phase;
   logic       wrap;
   logic       err;

   typedef struct {
      logic [3:0] q;
      logic [2:0] ph;
      logic       w;
      logic       e;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   logic [3:0] m_q;
   logic       m_mode;
   logic       m_err;
   logic       cur_mode;

   counter_ring_multimode #(.N(4)) dut (
      .clk      (clk),
      .ori      (ori),
      .en       (en),
      .dir      (dir),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .Q        (Q),
      .phase    (phase),
      .wrap     (wrap),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // State sequences in phase order; position in the table is the phase.
   function automatic logic [3:0] seq_at(input logic md, input int i);
      logic [3:0] rs [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [3:0] js [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                             4'b1111, 4'b1110, 4'b1100, 4'b1000};
      return md ? js[i] : rs[i];
   endfunction

   function automatic int idx_of(input logic md, input logic [3:0] q);
      int len;
      len = md ? 8 : 4;
      for (int i = 0; i < len; i++) begin
         if (seq_at(md, i) == q) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_q    = 4'b0001;
      m_mode = 1'b0;
      m_err  = 1'b0;
   endtask

   // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
   task automatic step_cyc(input logic e, input logic d, input logic m,
                           input logic l, input logic [3:0] lv);
      exp_t x;
      exp_t got;
      int   i;
      int   ni;
      int   len;
      @(negedge clk);
      en = e; dir = d; mode = m; load = l; load_val = lv;
      cur_mode = m;
      x.w = 1'b0;
      if (m != m_mode) begin
         m_mode = m;
         m_q    = m ? 4'b0000 : 4'b0001;
      end else if (l) begin
         if (idx_of(m_mode, lv) >= 0) begin
            m_q   = lv;
            m_err = 1'b0;
         end else begin
            m_q   = m_mode ? 4'b0000 : 4'b0001;
            m_err = 1'b1;
         end
      end else if (e) begin
         i = idx_of(m_mode, m_q);
         if (i < 0) begin
            m_q   = m_mode ? 4'b0000 : 4'b0001;
            m_err = 1'b1;
         end else begin
            len  = m_mode ? 8 : 4;
            ni   = d ? (i + len - 1) % len : (i + 1) % len;
            m_q  = seq_at(m_mode, ni);
            x.w  = (ni == 0);
         end
      end
      x.q  = m_q;
      i    = idx_of(m_mode, m_q);
      x.ph = (i < 0) ? 3'd0 : 3'(i);
      x.e  = m_err;
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         check("q",     32'(Q),     32'(got.q));
         check("phase", 32'(phase), 32'(got.ph));
         check("wrap",  32'(wrap),  32'(got.w));
         check("err",   32'(err),   32'(got.e));
      end
   endtask

   initial begin
      ori = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
      cur_mode = 1'b0;
      model_reset();
      #12;
      check("rst_q",     32'(Q),     32'h1);
      check("rst_phase", 32'(phase), 32'h0);
      check("rst_wrap",  32'(wrap),  32'h0);
      check("rst_err",   32'(err),   32'h0);
      @(negedge clk);
      ori = 1'b1;

      // Ring up, two full periods
      for (int k = 0; k < 8; k++) step_cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      // Ring down from 0001
      for (int k = 0; k < 4; k++) step_cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      // Illegal then legal load
      step_cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
      check("ld_bad_q", 32'(Q), 32'h1);
      step_cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
      check("ld_ok_q", 32'(Q), 32'h4);
      // Switch to Johnson and run a full period plus three steps
      step_cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
      check("j_seed_wrap", 32'(wrap), 32'h0);
      for (int k = 0; k < 11; k++) step_cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
      check("j_at_0111", 32'(Q), 32'h7);
      // Mode change outranks load
      step_cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000);
      check("mchg_q", 32'(Q), 32'h1);
      step_cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      check("mchg_step_q", 32'(Q), 32'h2);
      // Mixed random traffic
      for (int k = 0; k < 60; k++) begin
         step_cyc(1'($urandom_range(1)), 1'($urandom_range(1)),
                  cur_mode ^ ($urandom_range(15) == 0),
                  ($urandom_range(7) == 0), 4'($urandom_range(15)));
      end
      // Johnson mid-count, then asynchronous reset between edges
      for (int k = 0; k < 5; k++) step_cyc(1'b1, 1'($urandom_range(1)), 1'b1, 1'b0, 4'b0000);
      @(negedge clk);
      #2;
      ori = 1'b0;
      #1;
      check("async_q",    32'(Q),    32'h1);
      check("async_wrap", 32'(wrap), 32'h0);
      check("async_err",  32'(err),  32'h0);
      model_reset();
      @(negedge clk);
      ori = 1'b1;
      step_cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      check("post_rst_q", 32'(Q), 32'h0);
      for (int k = 0; k < 8; k++) step_cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_ring_multimode.md
# counter_ring_multimode

Parametrised successor to the fixed 4-bit ring counter. It provides an N-bit shift-register counter that runs as a one-hot ring or as a Johnson (twisted-ring) counter. It supports:
- bidirectional stepping, enable and synchronous parallel load;
- illegal-state detection with self-correction;
- a wrap pulse and a binary phase decode.

It serves as the sequencing and phase-generation primitive for the counters area, for example as a multiphase strobe source or a stepper-style sequencer.

## Interface
- N, 4: register width, N ≥ 2.
- PW, $clog2(2*N): phase output width (localparam, not overridable).

- clk  in  1  rising-edge clock
- ori  in  1  asynchronous active-low reset
- en  in  1  step enable
- dir  in  1  0 = shift toward MSB, 1 = shift toward LSB
- mode  in  1  0 = ring, 1 = Johnson
- load  in  1  synchronous parallel load
- load_val  in  N  load pattern
- Q  out  N  counter state (registered)
- phase  out  PW  binary decode of Q (combinational from Q)
- wrap  out  1  one-cycle pulse (registered)
- err  out  1  sticky illegal-state flag (registered)

## Operation
- Seeds:
  - ring seed = N'b0…01;
  - Johnson seed = all zeros.
- Internal mode_q holds the mode actually in effect.
- Legal states:
  - ring: exactly one bit set;
  - Johnson: thermometer pattern, i.e. Q = ones in bits [k-1:0] with zeros above, or ones in bits [N-1:k] with zeros below, for k in 0..N.
- Step functions:
  - ring, dir=0: {Q[N-2:0],Q[N-1]}
  - ring, dir=1: {Q[0],Q[N-1:1]}
  - Johnson, dir=0: {Q[N-2:0],~Q[N-1]}
  - Johnson, dir=1: {~Q[0],Q[N-1:1]}
- Per-edge priority (first match wins):
  1. mode ≠ mode_q: Q ← seed(mode), mode_q ← mode. load and en are ignored this cycle.
  2. load:
     - load_val legal for mode_q: Q ← load_val, err ← 0.
     - otherwise: Q ← seed(mode_q), err ← 1.
  3. en with Q illegal: Q ← seed(mode_q), err ← 1.
  4. en: Q ← step(Q).
  5. Otherwise Q holds.
- wrap ← 1 only when case 4 fires and step(Q) equals seed(mode_q); otherwise 0. Loads, mode changes and corrections never raise wrap.
- err: set as above. Cleared only by reset or by a legal load.
- phase:
  - ring: index of the set bit;
  - Johnson: Q[N-1]=0 → popcount(Q), else 2N − popcount(Q);
  - 0 whenever Q is illegal for mode_q.
- Cycle lengths: ring period N steps, Johnson period 2N steps, in either direction.

## Timing
- Reset (ori=0, asynchronous): Q = ring seed, mode_q = 0, wrap = 0, err = 0. Release is synchronised by the surrounding design.
- mode=1 held through reset release: Q switches to Johnson seed on the first edge, with no wrap.
- Latency: one cycle from en/load/mode to Q. phase follows Q combinationally in the same cycle. wrap is coincident with the Q that equals the seed.
- Reset asserted mid-operation forces the reset values immediately, independent of clk.
- dir may change every cycle. Each step uses the dir sampled at that edge.
- en=0 with an illegal Q: no correction and no err. Q holds until en, load or a mode change.

## Structure
- Package counter_ring_pkg holds:
  - MODE_RING/MODE_JOHNSON and DIR_UP/DIR_DOWN constants;
  - seed, step and legality functions, parametrised via N.
- Sub-module counter_ring_decode (combinational) computes legal and phase from Q and mode_q. It is instantiated once and reused for load_val legality by a second instance.
- The top level holds the Q, mode_q, wrap and err registers and the priority mux.

## Test plan
1. N=4, reset, mode=0, dir=0, en=1 for 8 cycles:
   - Q = 0010, 0100, 1000, 0001 (wrap=1), then the sequence repeats with wrap on cycle 8;
   - phase = 1, 2, 3, 0.
2. N=4, mode=1 from reset, dir=0, en=1:
   - first edge: Q = 0000 with wrap=0;
   - then Q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 (wrap=1);
   - phase = 1..7, 0.
3. Ring mode, dir=1, en=1 from 0001: Q = 1000, 0100, 0010, 0001 (wrap=1).
4. Ring mode, load=1, load_val=0110:
   - next Q = 0001, err=1;
   - then load_val=0100: Q = 0100, err=0.
5. Johnson running at Q=0111, assert mode=0 together with load=1 (load_val=1000):
   - next Q = 0001, load ignored, wrap=0;
   - following en step: Q = 0010.
6. Mid-count in Johnson mode, assert ori=0 between clock edges:
   - Q = 0001, wrap=0, err=0 immediately;
   - with mode still 1, the first edge after release gives Q = 0000.
